// File: rtl/fir_tap_sequencer.sv
// Sequences one FIR output per accepted sample: TAPS MAC cycles over a circular delay line, then a held result.
// Define FIR_TAP_SEQUENCER_SAT_EN to get Q15-scaled, saturated out_y instead of the raw accumulator.
module fir_tap_sequencer #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int AW   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_sample,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DW-1:0]     coef_wdata,
  output logic [DW-1:0]     mac_x,
  output logic [DW-1:0]     mac_coeff,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [2*DW-1:0]   mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_y
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;

  state_t          state;
  logic [AW-1:0]   k;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   x_idx;
  logic [DW-1:0]   delay [TAPS];
  logic [DW-1:0]   coef  [TAPS];
  logic [2*DW-1:0] y_next;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  // wp already points past the newest sample once RUN begins
  assign x_idx    = wp - AW'(1) - k;
  assign in_ready = (state == IDLE);

  always_comb begin
    mac_x     = '0;
    mac_coeff = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    if (state == RUN) begin
      mac_x     = delay[x_idx];
      mac_coeff = coef[k];
      mac_en    = 1'b1;
      mac_clr   = (k == '0);
    end
  end

`ifdef FIR_TAP_SEQUENCER_SAT_EN
  localparam logic signed [2*DW-1:0] SAT_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [2*DW-1:0] acc_sh;

  always_comb begin
    acc_sh = $signed(mac_acc) >>> (DW - 1);
    if (acc_sh > SAT_MAX)
      y_next = SAT_MAX;
    else if (acc_sh < SAT_MIN)
      y_next = SAT_MIN;
    else
      y_next = acc_sh;
  end
`else
  assign y_next = mac_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      wp        <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_we)
            coef[coef_addr] <= coef_wdata;
          if (in_valid) begin
            delay[wp] <= in_sample;
            wp        <= (wp == LAST_TAP) ? '0 : wp + AW'(1);
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (k == LAST_TAP) begin
            k     <= '0;
            state <= WAIT;
          end else begin
            k <= k + AW'(1);
          end
        end
        // mac_acc holds the final sum during this cycle
        WAIT: begin
          out_y     <= y_next;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural saturating MAC; saturation cases need FIR_TAP_SEQUENCER_SAT_EN.
module tb_fir_tap_sequencer;
  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_sample = '0;
  logic            coef_we = 1'b0;
  logic [AW-1:0]   coef_addr = '0;
  logic [DW-1:0]   coef_wdata = '0;
  logic [DW-1:0]   mac_x;
  logic [DW-1:0]   mac_coeff;
  logic            mac_en;
  logic            mac_clr;
  logic [2*DW-1:0] mac_acc;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] out_y;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mac_x(mac_x), .mac_coeff(mac_coeff), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator clamps to the 2*DW signed range instead of wrapping
  logic signed [2*DW-1:0] acc;
  longint prod, sum;
  assign mac_acc = acc;
  always @(posedge clk) begin
    if (mac_en) begin
      prod = $signed(mac_x) * $signed(mac_coeff);
      sum  = mac_clr ? prod : longint'(acc) + prod;
      if (sum > 64'sd2147483647) sum = 64'sd2147483647;
      if (sum < -64'sd2147483648) sum = -64'sd2147483648;
      acc <= sum[31:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_coef(input int addr, input logic [DW-1:0] data);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic start_sample(input string tag, input logic [DW-1:0] s);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_sample = s;
    tick();
    in_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_sample(input string tag, input logic [2*DW-1:0] exp, input int hold, input bit chk_y);
    while (!out_valid && (cyc - t0) < 300) begin
      if ((cyc - t0) == TAPS) check({tag, "_wait_mac_en"}, mac_en, 0);
      tick();
    end
    check({tag, "_latency"}, cyc - t0, TAPS + 1);
    if (chk_y) check({tag, "_y"}, out_y, exp);
    if (hold > 0) begin
      in_valid  = 1'b1;
      in_sample = 16'h1234;
      for (int i = 0; i < hold; i++) begin
        tick();
        check($sformatf("%s_bp_valid%0d", tag, i), out_valid, 1);
        check($sformatf("%s_bp_y%0d", tag, i), out_y, exp);
        check($sformatf("%s_bp_ready%0d", tag, i), in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  logic [DW-1:0] imp_s [4] = '{16'd1, 16'd0, 16'd0, 16'd0};

  initial begin
    int n;
    #1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_x", mac_x, 0);
    check("rst_mac_coeff", mac_coeff, 0);

`ifndef FIR_TAP_SEQUENCER_SAT_EN
    // Impulse response with coef[k] = k+1; backpressure on the last output
    for (int i = 0; i < TAPS; i++) load_coef(i, DW'(i + 1));
    for (int i = 0; i < 4; i++) begin
      start_sample($sformatf("imp%0d", i), imp_s[i]);
      if (i == 0) begin
        check("imp_k0_clr", mac_clr, 1);
        check("imp_k0_en", mac_en, 1);
        check("imp_k0_x", mac_x, 1);
        check("imp_k0_coeff", mac_coeff, 1);
        tick();
        check("imp_k1_clr", mac_clr, 0);
        check("imp_k1_x", mac_x, 0);
        check("imp_k1_coeff", mac_coeff, 2);
      end
      finish_sample($sformatf("imp%0d", i), 32'(i + 1), (i == 3) ? 10 : 0, 1'b1);
    end

    // Coefficient write attempted mid-run must be ignored
    do_reset();
    for (int i = 0; i < TAPS; i++) load_coef(i, DW'(i + 1));
    start_sample("cw1", 16'd1);
    repeat (5) tick();
    load_coef(0, 16'h0005);
    finish_sample("cw1", 32'd1, 0, 1'b1);
    start_sample("cw2", 16'd1);
    finish_sample("cw2", 32'd3, 0, 1'b1);

    // Reset at k = 20 aborts the run; then same-edge coef write + sample
    do_reset();
    load_coef(0, 16'd2);
    start_sample("ab", 16'd7);
    repeat (20) tick();
    check("ab_k20_en", mac_en, 1);
    do_reset();
    check("ab_in_ready", in_ready, 1);
    check("ab_mac_en", mac_en, 0);
    n = 0;
    repeat (100) begin
      tick();
      if (out_valid) n++;
    end
    check("ab_no_valid", n, 0);
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = 16'd2;
    start_sample("ab2", 16'd3);
    coef_we = 1'b0;
    finish_sample("ab2", 32'd6, 0, 1'b1);

    // Delay-line wrap: only coef[63] set, output n equals sample n-63
    do_reset();
    load_coef(63, 16'd1);
    for (int i = 0; i < 70; i++) begin
      start_sample($sformatf("wrap%0d", i), DW'(100 + i));
      finish_sample($sformatf("wrap%0d", i), (i >= 63) ? 32'(100 + i - 63) : 32'd0, 0, 1'b1);
    end
`else
    // Saturation: full-scale positive and negative windows
    for (int i = 0; i < TAPS; i++) load_coef(i, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) begin
      start_sample($sformatf("satp%0d", i), 16'h7FFF);
      finish_sample($sformatf("satp%0d", i), 32'h00007FFF, 0, i == TAPS - 1);
    end
    for (int i = 0; i < TAPS; i++) begin
      start_sample($sformatf("satn%0d", i), 16'h8000);
      finish_sample($sformatf("satn%0d", i), 32'hFFFF8000, 0, i == TAPS - 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
